// File: rtl/piano_note_sched_if.sv
// Key/mode inputs and note outputs shared by the note scheduler and its driver.
// The slave modport is the scheduler's view; master is the driver/observer side.
interface piano_note_sched_if;
    logic       MODE;
    logic [7:0] sw;
    logic [2:0] note;
    logic       note_on;
    logic [7:0] Led;
    logic [3:0] song_pos;
    logic       auto_busy;

    modport master (
        output MODE, sw,
        input  note, note_on, Led, song_pos, auto_busy
    );

    modport slave (
        input  MODE, sw,
        output note, note_on, Led, song_pos, auto_busy
    );
endinterface

// File: rtl/piano_note_sched.sv
// Note scheduler: live keys override an autoplay song; SONG_LOOP_EN makes the song loop forever.
// Latency: 1 cycle from MODE/sw sampling to every (registered) output.
// Backpressure: none, the tone generator consumes note/note_on every cycle.
module piano_note_sched #(
    parameter int BEAT_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int SONG_LEN    = 15
) (
    input  logic               CLK,
    input  logic               RESET,
    piano_note_sched_if.slave  bus
);

    localparam int MAXC = (3 * BEAT_CYCLES > GAP_CYCLES) ? 3 * BEAT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MANUAL,
        S_AUTO_NOTE,
        S_AUTO_GAP,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_note;
    logic            r_note_on;
    logic [7:0]      r_led;
    logic [3:0]      r_song_pos;
    logic            r_auto_busy;
    logic [CW-1:0]   r_cnt;

    state_t          w_state_nxt;
    logic [2:0]      w_note_nxt;
    logic            w_on_nxt;
    logic [7:0]      w_led_nxt;
    logic [3:0]      w_pos_nxt;
    logic            w_busy_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_manual;
    logic            w_start;
    logic [4:0]      w_entry;
    logic [1:0]      w_len;
    logic            w_key_any;
    logic [2:0]      w_key;
    logic [4:0]      w_pos_inc;

    // Entry = {note, length in beats}; anything past the song is an end marker.
    function automatic logic [4:0] song_rom(input logic [3:0] idx);
        logic [4:0] e;
        case (idx)
            4'd0:    e = {3'd5, 2'd1};
            4'd1:    e = {3'd5, 2'd1};
            4'd2:    e = {3'd4, 2'd1};
            4'd3:    e = {3'd3, 2'd1};
            4'd4:    e = {3'd3, 2'd1};
            4'd5:    e = {3'd4, 2'd1};
            4'd6:    e = {3'd5, 2'd1};
            4'd7:    e = {3'd6, 2'd1};
            4'd8:    e = {3'd7, 2'd1};
            4'd9:    e = {3'd7, 2'd1};
            4'd10:   e = {3'd6, 2'd1};
            4'd11:   e = {3'd5, 2'd1};
            4'd12:   e = {3'd5, 2'd1};
            4'd13:   e = {3'd4, 2'd1};
            4'd14:   e = {3'd4, 2'd2};
            default: e = 5'd0;
        endcase
        if (int'(idx) >= SONG_LEN) begin
            e = 5'd0;
        end
        return e;
    endfunction

    // Highest set key wins.
    function automatic logic [2:0] hi_key(input logic [7:0] k);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                n = 3'(i);
            end
        end
        return n;
    endfunction

    assign w_key_any = |bus.sw;
    assign w_key     = hi_key(bus.sw);
    assign w_pos_inc = {1'b0, r_song_pos} + 5'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note;
        w_on_nxt    = 1'b0;
        w_pos_nxt   = r_song_pos;
        w_cnt_nxt   = r_cnt;
        w_manual    = 1'b0;
        w_start     = 1'b0;
        w_entry     = 5'd0;
        w_len       = 2'd0;
        w_led_nxt   = 8'd0;
        w_busy_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.MODE) begin
                    w_state_nxt = S_MANUAL;
                    w_manual    = 1'b1;
                end else if (!w_key_any) begin
                    w_state_nxt = S_AUTO_NOTE;
                    w_pos_nxt   = 4'd0;
                    w_start     = 1'b1;
                end
            end
            S_MANUAL: begin
                if (bus.MODE) begin
                    w_manual = 1'b1;
                end else begin
                    w_state_nxt = S_AUTO_NOTE;
                    w_pos_nxt   = 4'd0;
                    w_start     = 1'b1;
                end
            end
            S_AUTO_NOTE, S_AUTO_GAP, S_PAUSE: begin
                if (bus.MODE) begin
                    w_state_nxt = S_MANUAL;
                    w_pos_nxt   = 4'd0;
                    w_cnt_nxt   = '0;
                    w_manual    = 1'b1;
                end else if (w_key_any) begin
                    w_state_nxt = S_PAUSE;
                    w_manual    = 1'b1;
                end else if (r_state == S_PAUSE) begin
                    // Resume replays the interrupted entry from its start.
                    w_state_nxt = S_AUTO_NOTE;
                    w_start     = 1'b1;
                end else if (r_state == S_AUTO_NOTE) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_AUTO_GAP;
                        w_cnt_nxt   = CW'(GAP_CYCLES - 1);
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                        w_on_nxt  = 1'b1;
                    end
                end else begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end else if (int'(w_pos_inc) < SONG_LEN) begin
                        w_state_nxt = S_AUTO_NOTE;
                        w_pos_nxt   = w_pos_inc[3:0];
                        w_start     = 1'b1;
                    end else begin
`ifdef SONG_LOOP_EN
                        w_state_nxt = S_AUTO_NOTE;
                        w_pos_nxt   = 4'd0;
                        w_start     = 1'b1;
`else
                        w_state_nxt = S_DONE;
                        w_pos_nxt   = (SONG_LEN > 15) ? 4'd15 : 4'(SONG_LEN);
`endif
                    end
                end
            end
            S_DONE: begin
                if (bus.MODE) begin
                    w_state_nxt = S_MANUAL;
                    w_pos_nxt   = 4'd0;
                    w_cnt_nxt   = '0;
                    w_manual    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_manual && w_key_any) begin
            w_note_nxt = w_key;
            w_on_nxt   = 1'b1;
        end

        if (w_start) begin
            w_entry    = song_rom(w_pos_nxt);
            w_len      = (w_entry[1:0] == 2'd0) ? 2'd1 : w_entry[1:0];
            w_note_nxt = w_entry[4:2];
            w_on_nxt   = 1'b1;
            w_cnt_nxt  = CW'(int'(w_len) * BEAT_CYCLES - 1);
        end

        if (w_on_nxt) begin
            w_led_nxt = 8'd1 << w_note_nxt;
        end

        w_busy_nxt = (w_state_nxt == S_AUTO_NOTE) || (w_state_nxt == S_AUTO_GAP) ||
                     (w_state_nxt == S_PAUSE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_note      <= 3'd0;
            r_note_on   <= 1'b0;
            r_led       <= 8'd0;
            r_song_pos  <= 4'd0;
            r_auto_busy <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_note      <= w_note_nxt;
            r_note_on   <= w_on_nxt;
            r_led       <= w_led_nxt;
            r_song_pos  <= w_pos_nxt;
            r_auto_busy <= w_busy_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.note      = r_note;
    assign bus.note_on   = r_note_on;
    assign bus.Led       = r_led;
    assign bus.song_pos  = r_song_pos;
    assign bus.auto_busy = r_auto_busy;

endmodule

// File: tb/tb_piano_note_sched.sv
// Random + directed stimulus for piano_note_sched, scored against an elapsed-time song model.
module tb_piano_note_sched;

    localparam int BEAT = 4;
    localparam int GAP  = 1;
    localparam int SLEN = 15;

    logic CLK;
    logic RESET;

    piano_note_sched_if bus();

    piano_note_sched #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .SONG_LEN    (SLEN)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] note;
        logic       on;
        logic [7:0] led;
        logic [3:0] pos;
        logic       busy;
    } exp_t;

    typedef enum {P_IDLE, P_MAN, P_PLAY, P_PAUSE, P_DONE} ph_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   SONG[15] = '{5, 5, 4, 3, 3, 4, 5, 6, 7, 7, 6, 5, 5, 4, 4};

    ph_t        ph;
    int         pos;
    int         t;
    logic [2:0] e_note;

    function automatic int dur(int p);
        return ((p == 14) ? 2 : 1) * BEAT;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ph     = P_IDLE;
        pos    = 0;
        t      = 0;
        e_note = 3'd0;
    endtask

    // One clock of the song rules: t counts cycles elapsed in the current entry.
    task automatic model_step(input logic m, input logic [7:0] s);
        int   hi;
        logic e_on;
        exp_t e;
        hi   = -1;
        e_on = 1'b0;
        for (int i = 0; i < 8; i++) if (s[i]) hi = i;

        if (ph == P_IDLE || ph == P_MAN) begin
            if (m) ph = P_MAN;
            else if (ph == P_MAN || s == 8'd0) begin
                ph = P_PLAY; pos = 0; t = 0;
            end
        end else begin
            if (m) begin
                ph = P_MAN; pos = 0;
            end else if (ph == P_DONE) begin
                ph = P_DONE;
            end else if (s != 8'd0) begin
                ph = P_PAUSE;
            end else if (ph == P_PAUSE) begin
                ph = P_PLAY; t = 0;
            end else begin
                t++;
                if (t >= dur(pos) + GAP) begin
                    pos++;
                    t = 0;
                    if (pos >= SLEN) begin
`ifdef SONG_LOOP_EN
                        pos = 0;
`else
                        ph = P_DONE;
`endif
                    end
                end
            end
        end

        if (ph == P_MAN || ph == P_PAUSE) begin
            if (hi >= 0) begin
                e_note = 3'(hi);
                e_on   = 1'b1;
            end
        end else if (ph == P_PLAY) begin
            e_note = 3'(SONG[pos]);
            e_on   = (t < dur(pos));
        end

        e.note = e_note;
        e.on   = e_on;
        e.led  = e_on ? (8'd1 << e_note) : 8'd0;
        e.pos  = 4'(pos);
        e.busy = (ph == P_PLAY) || (ph == P_PAUSE);
        q.push_back(e);
    endtask

    task automatic drive(input logic m, input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            bus.MODE = m;
            bus.sw   = s;
            model_step(m, s);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 8) begin
            @(posedge CLK);
            #2;
            n++;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_cleared(string tag);
        chk({tag, "_note"},     int'(bus.note),      0);
        chk({tag, "_note_on"},  int'(bus.note_on),   0);
        chk({tag, "_led"},      int'(bus.Led),       0);
        chk({tag, "_song_pos"}, int'(bus.song_pos),  0);
        chk({tag, "_busy"},     int'(bus.auto_busy), 0);
    endtask

    // Monitor: one expectation per clock once stimulus is flowing.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("note",      int'(bus.note),      int'(e.note));
                chk("note_on",   int'(bus.note_on),   int'(e.on));
                chk("led",       int'(bus.Led),       int'(e.led));
                chk("song_pos",  int'(bus.song_pos),  int'(e.pos));
                chk("auto_busy", int'(bus.auto_busy), int'(e.busy));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET    = 1'b0;
        bus.MODE = 1'b1;
        bus.sw   = 8'hFF;
        repeat (3) @(posedge CLK);
        #1;
        check_cleared("reset");
        model_reset();
        RESET = 1'b1;

        drive(1'b1, 8'hFF, 2);
        drive(1'b1, 8'h18, 2);
        drive(1'b1, 8'h00, 2);

        // Whole song through to the end.
        drive(1'b0, 8'h00, 95);
        drive(1'b1, 8'h00, 2);

        // Pause during entry 3, resume, then manual takeover mid-song.
        drive(1'b0, 8'h00, 17);
        drive(1'b0, 8'h40, 3);
        drive(1'b0, 8'h00, 6);
        drive(1'b1, 8'h00, 2);

        for (int sg = 0; sg < 40; sg++) begin
            int k;
            int n;
            k = $urandom_range(0, 9);
            if (k < 2) begin
                drive(1'b1, 8'($urandom), $urandom_range(1, 6));
            end else if (k < 4) begin
                drive(1'b0, 8'($urandom_range(1, 255)), $urandom_range(1, 5));
            end else if (k < 9) begin
                drive(1'b0, 8'h00, $urandom_range(1, 25));
            end else begin
                n = $urandom_range(1, 4);
                for (int c = 0; c < n; c++)
                    drive(1'b0, ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00, 1);
            end
        end

        // Asynchronous reset while a note is sounding.
        drive(1'b1, 8'h00, 1);
        drive(1'b0, 8'h00, 2);
        drain();
        #1;
        RESET = 1'b0;
        #1;
        check_cleared("async_reset");
        model_reset();
        RESET = 1'b1;

        drive(1'b0, 8'h05, 2);
        drive(1'b0, 8'h00, 12);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
